// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - access-size encodings used on MemRead / MemWrite
//     - FSM state type
//     - lane_be():      byte-enable pattern for a size / byte offset pair
//     - is_aligned():   natural-alignment test for a size / byte offset pair
// ---------------------------------------------------------------------------
package lsu_pkg;

  // Size encodings shared by MemRead and MemWrite.
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // Byte enables for an access of 'size' starting at byte offset 'off'
  // inside a little-endian 32-bit word (bit i = byte lane i).
  function automatic logic [3:0] lane_be(input logic [1:0] size,
                                         input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Halves must sit on an even byte, words on a word boundary.
  function automatic logic is_aligned(input logic [1:0] size,
                                      input logic [1:0] off);
    logic ok;
    case (size)
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
//   Purely combinational byte-lane steering for the load/store unit.
//
//   Store path (driven from the live request in IDLE):
//     st_size, st_off, st_data  -> st_be     byte enables
//                                  st_wdata  lane-replicated store data
//                                  st_legal  size/offset alignment is legal
//   Load path (driven from the latched request and the memory read word):
//     ld_size, ld_off, ld_unsigned, ld_rdata -> ld_result  extended load value
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        st_legal,

  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sign;

  // ---------------- store path ----------------
  // Store data is replicated across every lane it could land in, so the
  // memory only has to honour the byte enables.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    st_wdata = st_data;
    st_be    = lane_be(st_size, st_off);
    st_legal = is_aligned(st_size, st_off);
    case (st_size)
      SZ_BYTE: st_wdata = {4{st_data[7:0]}};
      SZ_HALF: st_wdata = {2{st_data[15:0]}};
      default: st_wdata = st_data;
    endcase
  end

  // ---------------- load path ----------------
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
  end

  // A legal half access only ever starts at offset 0 or 2, so addr[1] picks it.
  assign ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  always_comb begin
    ld_sign   = 1'b0;
    ld_result = ld_rdata;
    case (ld_size)
      SZ_BYTE: begin
        ld_sign   = ~ld_unsigned & ld_byte[7];
        ld_result = {{24{ld_sign}}, ld_byte};
      end
      SZ_HALF: begin
        ld_sign   = ~ld_unsigned & ld_half[15];
        ld_result = {{16{ld_sign}}, ld_half};
      end
      default: ld_result = ld_rdata;  // word: extension is irrelevant
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory-access stage behind the ALU. Accepts one load or store per
//   instruction, issues it on a word-wide req/ready memory port, freezes the
//   core with 'stall' until it completes and returns extended load data.
//   Misaligned or read+write requests are rejected with 'access_err'.
//
//   Core side:
//     clk, reset         clock, asynchronous active-high reset
//     MemRead, MemWrite  access size (00 none, 01 byte, 10 half, 11 word)
//     load_unsigned      1 = zero-extend byte/half loads
//     addr, write_data   byte address, right-justified store data
//     stall              hold the core (inputs must stay stable)
//     load_data          registered, extended load result
//     load_valid         one-cycle pulse when load_data is fresh
//     access_err         one-cycle pulse for an illegal request
//   Memory side:
//     mem_req, mem_we, mem_addr, mem_be, mem_wdata   request (held in REQ)
//     mem_ready          accept/complete strobe, only looked at in REQ
//     mem_rdata          read word, sampled on mem_req & mem_ready & ~mem_we
//
//   Flow: IDLE --legal request--> REQ --mem_ready--> RESP --> IDLE.
//   RESP is a deliberate dead cycle: the core still presents the finished
//   instruction's controls there, so nothing new may start from it.
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // fixed at 32; lane logic assumes four byte lanes
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [1:0]        MemRead,
  input  logic [1:0]        MemWrite,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,

  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              access_err,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t state;

  // Request decode in IDLE
  logic        req_any;
  logic        req_conflict;
  logic [1:0]  req_size;
  logic        req_legal;

  // Latched request context, used while the access is in flight
  logic        we_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        unsigned_q;

  // Lane steering results
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic              st_legal;
  logic [DATA_W-1:0] ld_result;

  // ---------------- request decode ----------------
  assign req_any      = (MemRead != SZ_NONE) || (MemWrite != SZ_NONE);
  assign req_conflict = (MemRead != SZ_NONE) && (MemWrite != SZ_NONE);
  // With no conflict at most one of the two is nonzero, so this picks the
  // active one; on a conflict the request is rejected regardless.
  assign req_size     = (MemWrite != SZ_NONE) ? MemWrite : MemRead;
  assign req_legal    = req_any && !req_conflict && st_legal;

  lsu_align u_align (
    .st_size     (req_size),
    .st_off      (addr[1:0]),
    .st_data     (write_data),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .st_legal    (st_legal),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (unsigned_q),
    .ld_rdata    (mem_rdata),
    .ld_result   (ld_result)
  );

  // ---------------- FSM and output registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_NONE;
      off_q      <= 2'b00;
      unsigned_q <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
      load_data  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values and ordering inside the block
      // cannot create simulation/synthesis mismatches.
      case (state)
        IDLE: begin
          if (req_legal) begin
            we_q       <= (MemWrite != SZ_NONE);
            size_q     <= req_size;
            off_q      <= addr[1:0];
            unsigned_q <= load_unsigned;
            mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
            mem_be     <= st_be;
            mem_wdata  <= st_wdata;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (!we_q) load_data <= ld_result;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- outputs decoded from state ----------------
  // mem_req comes straight off the state register, so an asynchronous reset
  // removes it immediately and abandons the in-flight access.
  assign mem_req    = (state == REQ);
  assign mem_we     = we_q;
  assign load_valid = (state == RESP) && !we_q;

  // Reset masks the live-request terms so the core is released while reset
  // is held even if it is still presenting a request.
  assign stall      = !reset && (((state == IDLE) && req_legal) || (state == REQ));
  assign access_err = !reset && (state == IDLE) && req_any && !req_legal;

endmodule
